// File: rtl/delay_sum.sv
// delay_sum: delay-and-sum beamformer frame accumulator.
// On every edge (either polarity) of the synchronized LRCK with i_enable set,
// walks o_ch_sel through all channels, sums the samples returned by the
// external mux, and publishes their mean on o_sum with a one-cycle o_valid.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_LRCK      I2S frame clock, asynchronous to i_clk
//   i_enable    gates the start of new frames
//   i_sample    signed mux data, valid one cycle after o_ch_sel
//   o_ch_sel    channel select to the external sample mux
//   o_sum       signed channel mean (floor), held until the next frame result
//   o_lr        LRCK level of the frame that produced o_sum
//   o_valid     one-cycle strobe: o_sum/o_lr are new
//   o_busy      high while a frame is being accumulated
//   o_drop_cnt  saturating count of edges dropped while busy
module delay_sum #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_LRCK,
  input  logic                      i_enable,
  input  logic [DATA_W-1:0]         i_sample,
  output logic [$clog2(NUM_CH)-1:0] o_ch_sel,
  output logic [DATA_W-1:0]         o_sum,
  output logic                      o_lr,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic [7:0]                o_drop_cnt
);

  localparam int SHIFT = $clog2(NUM_CH);
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_SEL_CNT = CNT_W'(NUM_CH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             lrck_meta;
  logic             lrck_sync;
  logic             lrck_prev;
  logic             lrck_edge;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             lr_cap;
  logic             start;

  // Sign-extended running sum including the sample on the bus this cycle.
  always_comb begin
    acc_next = acc + {{SHIFT{i_sample[DATA_W-1]}}, i_sample};
  end

  always_comb begin
    start = lrck_edge & i_enable;
  end

  assign o_busy = (state == ACC);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lrck_meta  <= 1'b0;
      lrck_sync  <= 1'b0;
      lrck_prev  <= 1'b0;
      lrck_edge  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      lr_cap     <= 1'b0;
      o_ch_sel   <= '0;
      o_sum      <= '0;
      o_lr       <= 1'b0;
      o_valid    <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      lrck_meta <= i_LRCK;
      lrck_sync <= lrck_meta;
      lrck_prev <= lrck_sync;
      lrck_edge <= lrck_sync ^ lrck_prev;
      o_valid   <= 1'b0;

      case (state)
        IDLE, DONE: begin
          // DONE accepts a new edge directly so back-to-back frames never drop.
          if (start) begin
            state    <= ACC;
            cnt      <= '0;
            acc      <= '0;
            o_ch_sel <= '0;
            lr_cap   <= lrck_prev;
          end else begin
            state <= IDLE;
          end
        end

        ACC: begin
          if (start && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
          end
          // cnt=c carries the sample for channel c-1 (mux latency of one cycle).
          if (cnt != '0) begin
            acc <= acc_next;
          end
          if (cnt == LAST_CNT) begin
            state    <= DONE;
            o_valid  <= 1'b1;
            o_sum    <= acc_next[ACC_W-1:SHIFT];
            o_lr     <= lr_cap;
            o_ch_sel <= '0;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            o_ch_sel <= (cnt < LAST_SEL_CNT) ? o_ch_sel + 1'b1 : '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sum.sv
// tb_delay_sum: directed/randomized bench for delay_sum (NUM_CH=8, DATA_W=24).
// The bench plays the external ring-buffer mux and predicts every frame result
// from the channel values with plain integer arithmetic.
module tb_delay_sum;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 24;
  localparam int LAT    = 3;  // cycles from an LRCK change to the edge cycle E

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              lrck   = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] sample = '0;
  logic [2:0]        ch_sel;
  logic [DATA_W-1:0] sum;
  logic              lr;
  logic              valid;
  logic              busy;
  logic [7:0]        drop_cnt;

  logic [DATA_W-1:0] chan [NUM_CH];
  int n_vec = 0;
  int n_err = 0;
  int drop_exp = 0;

  delay_sum #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_LRCK     (lrck),
    .i_enable   (enable),
    .i_sample   (sample),
    .o_ch_sel   (ch_sel),
    .o_sum      (sum),
    .o_lr       (lr),
    .o_valid    (valid),
    .o_busy     (busy),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock; afterwards the mux presents the channel selected last cycle.
  task automatic step();
    bit [2:0] sel_now;
    sel_now = ch_sel;
    @(posedge clk);
    #1;
    sample = chan[sel_now];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ":valid"},  32'(valid),    32'd0);
    check({tag, ":busy"},   32'(busy),     32'd0);
    check({tag, ":ch_sel"}, 32'(ch_sel),   32'd0);
    check({tag, ":sum"},    32'(sum),      32'd0);
    check({tag, ":lr"},     32'(lr),       32'd0);
    check({tag, ":drop"},   32'(drop_cnt), 32'd0);
  endtask

  // Mean of the channels, rounded toward minus infinity.
  function automatic logic [DATA_W-1:0] mean_model();
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < NUM_CH; i++) s += longint'(signed'(chan[i]));
    q = s / NUM_CH;
    if (s < 0 && (s % NUM_CH) != 0) q = q - 1;
    return q[DATA_W-1:0];
  endfunction

  task automatic rand_chan();
    for (int i = 0; i < NUM_CH; i++) chan[i] = DATA_W'($urandom);
  endtask

  task automatic fill_chan(input logic [DATA_W-1:0] v);
    for (int i = 0; i < NUM_CH; i++) chan[i] = v;
  endtask

  // One frame. e_off: step index at which E falls (rel = step - e_off).
  // inj: rel at which a second edge lands (0 = none). dis: rel after which
  // i_enable is dropped (0 = never).
  task automatic frame(input bit toggle, input int e_off, input int inj,
                       input int dis, input string tag);
    logic [DATA_W-1:0] exp_sum;
    logic              exp_lr;
    int                rel;
    bit                exp_busy;
    exp_sum = mean_model();
    enable  = 1'b1;
    if (toggle) lrck = ~lrck;
    exp_lr = lrck;
    for (int s = 1; s - e_off <= 11; s++) begin
      rel = s - e_off;
      step();
      exp_busy = (rel >= 1 && rel <= 9) || (inj == 10 && rel == 11);
      check({tag, ":valid"}, 32'(valid), 32'(rel == 10));
      check({tag, ":busy"},  32'(busy),  32'(exp_busy));
      check({tag, ":ch_sel"}, 32'(ch_sel),
            (rel >= 1 && rel <= NUM_CH) ? 32'(rel - 1) : 32'd0);
      if (rel == 10) begin
        check({tag, ":sum"}, 32'(sum), 32'(exp_sum));
        check({tag, ":lr"},  32'(lr),  32'(exp_lr));
      end
      if (rel == 11) begin
        check({tag, ":sum_hold"}, 32'(sum), 32'(exp_sum));
        check({tag, ":drop"}, 32'(drop_cnt), 32'(drop_exp));
      end
      if (inj != 0 && s == inj + e_off - LAT) begin
        lrck = ~lrck;
        if (inj >= 1 && inj <= 9 && drop_exp < 255) drop_exp++;
      end
      if (dis != 0 && rel == dis) enable = 1'b0;
    end
  endtask

  initial begin
    fill_chan(24'h000100);

    // Reset held with random inputs: everything stays cleared.
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      lrck   = 1'($urandom_range(1, 0));
      enable = 1'($urandom_range(1, 0));
      step();
      sample = DATA_W'($urandom);
      check_cleared("rst_hold");
    end

    // Release with LRCK high: counts as a rising edge.
    lrck   = 1'b1;
    enable = 1'b1;
    rst_n  = 1'b1;
    frame(1'b0, LAT, 0, 0, "rst_release");

    rand_chan();
    frame(1'b1, LAT, 0, 0, "rand_fall");
    fill_chan(24'h000100);
    frame(1'b1, LAT, 0, 0, "ones_rise");

    fill_chan(24'h7FFFFF);
    frame(1'b1, LAT, 0, 0, "max_pos");
    fill_chan(24'h800000);
    frame(1'b1, LAT, 0, 0, "max_neg");
    fill_chan(24'h000000);
    chan[5] = 24'hFFFFFF;
    frame(1'b1, LAT, 0, 0, "minus_one");
    for (int i = 0; i < NUM_CH; i++) chan[i] = (i % 2 == 0) ? 24'h000001 : 24'hFFFFFF;
    frame(1'b1, LAT, 0, 0, "alt_pm1");

    for (int f = 0; f < 4; f++) begin
      rand_chan();
      frame(1'b1, LAT, 0, 0, "rand");
    end

    // Enable low across four edges: ignored, not dropped.
    enable = 1'b0;
    for (int e = 0; e < 4; e++) begin
      lrck = ~lrck;
      for (int c = 0; c < 6; c++) begin
        step();
        check("en_off:valid", 32'(valid), 32'd0);
        check("en_off:busy",  32'(busy),  32'd0);
      end
    end
    check("en_off:drop", 32'(drop_cnt), 32'd0);

    // Enable falls mid-frame: frame still completes.
    rand_chan();
    frame(1'b1, LAT, 0, 4, "en_fall");

    // Reset pulse mid-frame; LRCK ends low so release creates no edge.
    if (lrck == 1'b0) begin
      enable = 1'b0;
      lrck   = 1'b1;
      for (int c = 0; c < 6; c++) step();
    end
    enable = 1'b1;
    lrck   = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    check("rst_mid:ch_sel", 32'(ch_sel), 32'd4);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    drop_exp = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      check("rst_mid:valid", 32'(valid), 32'd0);
      check("rst_mid:busy",  32'(busy),  32'd0);
    end
    check_cleared("rst_mid");
    rand_chan();
    frame(1'b1, LAT, 0, 0, "after_rst");

    // Collisions: a second edge at E+5 is dropped and counted, saturating.
    rand_chan();
    frame(1'b1, LAT, 5, 0, "collide_first");
    for (int n = 1; n < 300; n++) begin
      if (n % 37 == 0) rand_chan();
      frame(1'b1, LAT, 5, 0, "collide");
    end
    check("collide:drop_sat", 32'(drop_cnt), 32'd255);

    // Edge landing on DONE starts the next frame straight away, no drop.
    rand_chan();
    frame(1'b1, LAT, 10, 0, "done_inj");
    rand_chan();
    frame(1'b0, -1, 0, 0, "done_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
